regfile_param: RTL and testbench
================================

# regfile_param

Parametrised multi-read-port register file; successor to the fixed 32x32 two-read/one-write file register. Adds:
- configurable data width and depth;
- optional hard-wired zero register;
- optional same-cycle write-to-read bypass;
- a sequenced clear engine, so storage can map to reset-less memory.

Sits in the datapath between decode (read addresses) and writeback (write port).

## Interface
Parameters:
- DATA_W, 32, bits per entry
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries
- ZERO_REG, 1, 1 = entry 0 reads as 0 and ignores writes
- BYPASS, 1, 1 = read of the address being written returns write_data in the same cycle

Ports:
- clk  in  1  single clock, rising edge
- rst_all  in  1  reset, synchronous, active-high; starts a full clear sweep
- clr  in  1  synchronous clear request; starts a clear sweep when ready=1
- we  in  1  write enable
- write_addr  in  ADDR_W  write entry select
- write_data  in  DATA_W  write data
- read0_addr  in  ADDR_W  read port 0 select
- read1_addr  in  ADDR_W  read port 1 select
- read0_data  out  DATA_W  read port 0 data, combinational
- read1_data  out  DATA_W  read port 1 data, combinational
- ready  out  1  1 = file initialised; writes accepted
- wr_drop  out  1  one-cycle pulse: a write was presented while ready=0 and was discarded

## Operation
- Storage is a DEPTH x DATA_W array with no reset on the array itself.
- Clear engine states:
  - CLEAR: writes 0 to entry ptr each cycle; ptr increments.
  - IDLE: ready=1.
- Transitions:
  - rst_all=1 -> CLEAR, ptr=0. Overrides everything, including a sweep in progress.
  - CLEAR with ptr==DEPTH-1 -> IDLE. The last entry is cleared on that edge.
  - IDLE with clr=1 -> CLEAR, ptr=0.
  - clr while in CLEAR is ignored.
- While rst_all is held, ptr stays 0 and entry 0 is written 0 every cycle.
- Writes:
  - we=1, ready=1, and write_addr is not the zero register: write_data is stored at the rising edge.
  - we=1 and ready=0: the write is dropped and wr_drop=1 in the following cycle.
  - A write to entry 0 with ZERO_REG=1 is silently ignored; it is not a drop.
- Reads (purely combinational, both ports independent, same-address reads legal):
  - ready=0: read data = 0.
  - ZERO_REG=1 and address 0: data = 0.
  - BYPASS=1, we=1, ready=1, read addr == write_addr: data = write_data.
  - Otherwise: data = stored array value.
- Priority per read port: not-ready zero > zero register > bypass > array.

## Timing
- Reset values, in the cycle after rst_all is sampled high: ready=0, wr_drop=0, read0_data=read1_data=0, ptr=0.
- Clear latency: the sweep ends on the DEPTH-th rising edge after rst_all falls, or after clr is accepted. ready=1 from the following cycle.
  - Defaults: ready rises 32 cycles after rst_all deasserts.
- Write latency: 1 edge. Reads of the written entry see the new value in the next cycle, or in the same cycle when BYPASS=1.
- ready falls in the cycle after clr is accepted. A write presented in the same cycle as an accepted clr is still committed, then overwritten by the sweep.
- rst_all asserted mid-sweep restarts the sweep at ptr=0 on the next edge.
- ptr is ADDR_W bits wide. Terminal detection is on DEPTH-1, with no wrap beyond it.

## Structure
- Package regfile_pkg:
  - clear-state enum (IDLE, CLEAR);
  - helper function for DEPTH from ADDR_W.
- Sub-module regfile_clear_seq:
  - holds the FSM, ptr, ready and wr_drop;
  - outputs clear_en/clear_addr to the array write mux.
- Top level holds the array, the write mux (clear vs user write) and the two read muxes with zero/bypass logic.

## Test plan
- Reset: rst_all=1 for 3 cycles, then 0. ready=0 and both reads=0 for 32 cycles; ready=1 on cycle 33. Every address then reads 0x00000000.
- Write/read: write 0xDEADBEEF to entry 7. Next cycle read0_addr=7 gives 0xDEADBEEF; read1_addr=7 gives the same value on both ports.
- Bypass: with BYPASS=1, we=1, write_addr=5, write_data=0x12345678 and read0_addr=5 give read0_data=0x12345678 in the same cycle. With BYPASS=0 the old value is returned.
- Zero register: write 0xFFFFFFFF to entry 0. Read 0 returns 0 and wr_drop stays 0.
- Clear and drop:
  - Fill entries 1..31, pulse clr. ready falls the next cycle.
  - A write during the sweep gives wr_drop=1 one cycle later, and the data is absent after the sweep.
  - All entries read 0 after ready rises.
- Mid-sweep reset: assert rst_all at sweep cycle 10. The sweep restarts, and ready rises 32 cycles after rst_all deasserts.
- Parametric: rerun the above with DATA_W=16, ADDR_W=3 (ready after 8 cycles).

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and helpers for the parametrised register file and its clear sequencer.
package regfile_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clear_state_e;

    localparam int NUM_READ_PORTS = 2;

    function automatic int depth_of(input int addr_w);
        return 1 << addr_w;
    endfunction

endpackage

// File: rtl/regfile_clear_seq.sv
// Clear sequencer: sweeps zeros through every entry after reset or a clear request,
// gates user writes via ready and flags writes discarded while the sweep runs.
module regfile_clear_seq
    import regfile_pkg::*;
#(
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_all,
    input  logic              clr,
    input  logic              we,
    output logic              ready,
    output logic              wr_drop,
    output logic              clear_en,
    output logic [ADDR_W-1:0] clear_addr
);

    // DEPTH is a power of two, so the terminal pointer is all ones.
    localparam logic [ADDR_W-1:0] LAST_PTR = {ADDR_W{1'b1}};

    clear_state_e      state_reg, state_next;
    logic [ADDR_W-1:0] ptr_reg, ptr_next;
    logic              wr_drop_reg, wr_drop_next;

    always_ff @(posedge clk) begin
        if (rst_all) begin
            state_reg   <= CLEAR;
            ptr_reg     <= '0;
            wr_drop_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            ptr_reg     <= ptr_next;
            wr_drop_reg <= wr_drop_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        ptr_next     = ptr_reg;
        wr_drop_next = we && (state_reg != IDLE);
        case (state_reg)
            IDLE: begin
                if (clr) begin
                    state_next = CLEAR;
                    ptr_next   = '0;
                end
            end
            CLEAR: begin
                // clr is deliberately ignored here; the sweep always runs to completion.
                if (ptr_reg == LAST_PTR) begin
                    state_next = IDLE;
                    ptr_next   = '0;
                end else begin
                    ptr_next = ptr_reg + 1'b1;
                end
            end
            default: begin
                state_next = CLEAR;
                ptr_next   = '0;
            end
        endcase
    end

    assign ready      = (state_reg == IDLE);
    assign clear_en   = (state_reg == CLEAR);
    assign clear_addr = ptr_reg;
    assign wr_drop    = wr_drop_reg;

endmodule

// File: rtl/regfile_param.sv
// Parametrised register file: one write port, two combinational read ports, optional
// hard-wired zero entry and write-to-read bypass, zeroed by a sequenced sweep.
module regfile_param
    import regfile_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst_all,
    input  logic              clr,
    input  logic              we,
    input  logic [ADDR_W-1:0] write_addr,
    input  logic [DATA_W-1:0] write_data,
    input  logic [ADDR_W-1:0] read0_addr,
    input  logic [ADDR_W-1:0] read1_addr,
    output logic [DATA_W-1:0] read0_data,
    output logic [DATA_W-1:0] read1_data,
    output logic              ready,
    output logic              wr_drop
);

    localparam int DEPTH = depth_of(ADDR_W);

    logic              clear_en;
    logic [ADDR_W-1:0] clear_addr;

    regfile_clear_seq #(
        .ADDR_W(ADDR_W)
    ) u_clear_seq (
        .clk       (clk),
        .rst_all   (rst_all),
        .clr       (clr),
        .we        (we),
        .ready     (ready),
        .wr_drop   (wr_drop),
        .clear_en  (clear_en),
        .clear_addr(clear_addr)
    );

    logic user_we;
    assign user_we = we && ready && !((ZERO_REG != 0) && (write_addr == '0));

    // Single array write port shared by the sweep and user writes; they never overlap
    // because user writes require ready, which is low for the whole sweep.
    logic              arr_we;
    logic [ADDR_W-1:0] arr_addr;
    logic [DATA_W-1:0] arr_data;

    always_comb begin
        arr_we   = clear_en || user_we;
        arr_addr = clear_en ? clear_addr : write_addr;
        arr_data = clear_en ? '0 : write_data;
    end

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (arr_we) begin
            mem[arr_addr] <= arr_data;
        end
    end

    logic [ADDR_W-1:0] rd_addr [NUM_READ_PORTS];
    logic [DATA_W-1:0] rd_data [NUM_READ_PORTS];

    assign rd_addr[0] = read0_addr;
    assign rd_addr[1] = read1_addr;

    generate
        for (genvar gi = 0; gi < NUM_READ_PORTS; gi++) begin : g_read
            logic [DATA_W-1:0] data_mux;

            always_comb begin
                if (!ready) begin
                    data_mux = '0;
                end else if ((ZERO_REG != 0) && (rd_addr[gi] == '0)) begin
                    data_mux = '0;
                end else if ((BYPASS != 0) && we && (rd_addr[gi] == write_addr)) begin
                    data_mux = write_data;
                end else begin
                    data_mux = mem[rd_addr[gi]];
                end
            end

            assign rd_data[gi] = data_mux;
        end
    endgenerate

    assign read0_data = rd_data[0];
    assign read1_data = rd_data[1];

endmodule

// File: tb/tb_regfile_param.sv
// Randomised bench for regfile_param: three configurations share one stimulus stream
// and are checked against a countdown-based behavioural model.
module tb_regfile_param;

    localparam int NK = 3;

    logic        clk = 1'b0;
    logic        rst_all = 1'b0;
    logic        clr = 1'b0;
    logic        we = 1'b0;
    logic [4:0]  write_addr = '0;
    logic [31:0] write_data = '0;
    logic [4:0]  read0_addr = '0;
    logic [4:0]  read1_addr = '0;

    always #5 clk = ~clk;

    logic [31:0] a_rd0, a_rd1, b_rd0, b_rd1;
    logic [15:0] c_rd0, c_rd1;
    logic        a_ready, b_ready, c_ready;
    logic        a_drop, b_drop, c_drop;

    // Config A: 32x32, zero reg, bypass
    regfile_param #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)) dut_a (
        .clk(clk), .rst_all(rst_all), .clr(clr), .we(we),
        .write_addr(write_addr), .write_data(write_data),
        .read0_addr(read0_addr), .read1_addr(read1_addr),
        .read0_data(a_rd0), .read1_data(a_rd1), .ready(a_ready), .wr_drop(a_drop));

    // Config B: 32x32, no zero reg, no bypass
    regfile_param #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(0), .BYPASS(0)) dut_b (
        .clk(clk), .rst_all(rst_all), .clr(clr), .we(we),
        .write_addr(write_addr), .write_data(write_data),
        .read0_addr(read0_addr), .read1_addr(read1_addr),
        .read0_data(b_rd0), .read1_data(b_rd1), .ready(b_ready), .wr_drop(b_drop));

    // Config C: 8x16, zero reg, bypass
    regfile_param #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(1), .BYPASS(1)) dut_c (
        .clk(clk), .rst_all(rst_all), .clr(clr), .we(we),
        .write_addr(write_addr[2:0]), .write_data(write_data[15:0]),
        .read0_addr(read0_addr[2:0]), .read1_addr(read1_addr[2:0]),
        .read0_data(c_rd0), .read1_data(c_rd1), .ready(c_ready), .wr_drop(c_drop));

    logic [31:0] obs_rd0 [NK];
    logic [31:0] obs_rd1 [NK];
    logic        obs_ready [NK];
    logic        obs_drop [NK];

    assign obs_rd0[0] = a_rd0;
    assign obs_rd0[1] = b_rd0;
    assign obs_rd0[2] = {16'h0000, c_rd0};
    assign obs_rd1[0] = a_rd1;
    assign obs_rd1[1] = b_rd1;
    assign obs_rd1[2] = {16'h0000, c_rd1};
    assign obs_ready[0] = a_ready;
    assign obs_ready[1] = b_ready;
    assign obs_ready[2] = c_ready;
    assign obs_drop[0] = a_drop;
    assign obs_drop[1] = b_drop;
    assign obs_drop[2] = c_drop;

    int          cfg_depth [NK] = '{32, 32, 8};
    int          cfg_zero  [NK] = '{1, 0, 1};
    int          cfg_byp   [NK] = '{1, 0, 1};
    logic [31:0] cfg_dmask [NK] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_FFFF};

    // Model: a sweep is "cycles remaining until ready"; contents are zeroed at sweep start
    // since reads return 0 and writes are dropped until the sweep finishes.
    logic [31:0] mdl_mem [NK][32];
    int          mdl_left [NK];
    logic        mdl_drop [NK];

    int vectors = 0;
    int miscompares = 0;

    function automatic logic [31:0] exp_read(input int k, input logic [4:0] a);
        int ai;
        int wi;
        ai = int'(a) % cfg_depth[k];
        wi = int'(write_addr) % cfg_depth[k];
        if (mdl_left[k] != 0) return 32'h0;
        if (cfg_zero[k] != 0 && ai == 0) return 32'h0;
        if (cfg_byp[k] != 0 && we && wi == ai) return write_data & cfg_dmask[k];
        return mdl_mem[k][ai];
    endfunction

    task automatic model_edge();
        for (int k = 0; k < NK; k++) begin
            int  wi;
            bit  ready_now;
            wi = int'(write_addr) % cfg_depth[k];
            ready_now = (mdl_left[k] == 0);
            mdl_drop[k] = we && !ready_now;
            if (ready_now && we && !(cfg_zero[k] != 0 && wi == 0))
                mdl_mem[k][wi] = write_data & cfg_dmask[k];
            if (rst_all) begin
                mdl_left[k] = cfg_depth[k];
                mdl_drop[k] = 1'b0;
                for (int i = 0; i < 32; i++) mdl_mem[k][i] = 32'h0;
            end else if (ready_now && clr) begin
                mdl_left[k] = cfg_depth[k];
                for (int i = 0; i < 32; i++) mdl_mem[k][i] = 32'h0;
            end else if (mdl_left[k] > 0) begin
                mdl_left[k] = mdl_left[k] - 1;
            end
        end
    endtask

    // Advance one clock; inputs change only at the falling edge.
    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic test_reset();
        int first_ready [NK];
        rst_all = 1'b1; clr = 1'b0; we = 1'b1;
        write_addr = 5'd3; write_data = 32'hCAFE_F00D;
        for (int c = 0; c < 3; c++) begin
            tick();
            we = 1'b0;
            #1;
            for (int k = 0; k < NK; k++) begin
                vectors++;
                if (obs_ready[k] !== 1'b0 || obs_drop[k] !== 1'b0 ||
                    obs_rd0[k] !== 32'h0 || obs_rd1[k] !== 32'h0) begin
                    miscompares++;
                    $display("FAIL reset_state cfg=%0d ready=%b drop=%b rd0=%h rd1=%h required 0/0/0/0",
                             k, obs_ready[k], obs_drop[k], obs_rd0[k], obs_rd1[k]);
                end
            end
        end
        rst_all = 1'b0;
        for (int k = 0; k < NK; k++) first_ready[k] = -1;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            read0_addr = 5'($urandom_range(0, 31));
            read1_addr = 5'($urandom_range(0, 31));
            #1;
            for (int k = 0; k < NK; k++) begin
                if (obs_ready[k] === 1'b1 && first_ready[k] < 0) first_ready[k] = cyc;
                vectors++;
                if (obs_ready[k] !== (mdl_left[k] == 0) ||
                    obs_rd0[k] !== exp_read(k, read0_addr) ||
                    obs_rd1[k] !== exp_read(k, read1_addr)) begin
                    miscompares++;
                    $display("FAIL reset_sweep cfg=%0d cyc=%0d ready=%b rd0=%h rd1=%h required %b/%h/%h",
                             k, cyc, obs_ready[k], obs_rd0[k], obs_rd1[k],
                             (mdl_left[k] == 0), exp_read(k, read0_addr), exp_read(k, read1_addr));
                end
            end
            tick();
        end
        for (int k = 0; k < NK; k++) begin
            vectors++;
            if (first_ready[k] != cfg_depth[k] + 1) begin
                miscompares++;
                $display("FAIL ready_latency cfg=%0d first ready cycle %0d required %0d",
                         k, first_ready[k], cfg_depth[k] + 1);
            end
        end
        for (int a = 0; a < 32; a++) begin
            read0_addr = 5'(a);
            read1_addr = 5'(31 - a);
            #1;
            for (int k = 0; k < NK; k++) begin
                vectors++;
                if (obs_rd0[k] !== 32'h0 || obs_rd1[k] !== 32'h0) begin
                    miscompares++;
                    $display("FAIL post_reset_zero cfg=%0d addr=%0d rd0=%h rd1=%h required 0",
                             k, a, obs_rd0[k], obs_rd1[k]);
                end
            end
            tick();
        end
    endtask

    task automatic test_write_read();
        we = 1'b1; write_addr = 5'd7; write_data = 32'hDEAD_BEEF;
        read0_addr = 5'd3; read1_addr = 5'd4;
        tick();
        we = 1'b0; read0_addr = 5'd7; read1_addr = 5'd7;
        #1;
        for (int k = 0; k < NK; k++) begin
            vectors++;
            if (obs_rd0[k] !== (32'hDEAD_BEEF & cfg_dmask[k]) ||
                obs_rd1[k] !== (32'hDEAD_BEEF & cfg_dmask[k])) begin
                miscompares++;
                $display("FAIL write_read cfg=%0d rd0=%h rd1=%h required %h",
                         k, obs_rd0[k], obs_rd1[k], 32'hDEAD_BEEF & cfg_dmask[k]);
            end
        end
        tick();
    endtask

    task automatic test_bypass();
        logic [31:0] req [NK];
        we = 1'b1; write_addr = 5'd5; write_data = 32'h1111_1111;
        tick();
        write_data = 32'h1234_5678; read0_addr = 5'd5; read1_addr = 5'd5;
        req[0] = 32'h1234_5678;
        req[1] = 32'h1111_1111;
        req[2] = 32'h0000_5678;
        #1;
        for (int k = 0; k < NK; k++) begin
            vectors++;
            if (obs_rd0[k] !== req[k] || obs_rd1[k] !== req[k]) begin
                miscompares++;
                $display("FAIL bypass cfg=%0d rd0=%h rd1=%h required %h", k, obs_rd0[k], obs_rd1[k], req[k]);
            end
        end
        tick();
        we = 1'b0;
        #1;
        for (int k = 0; k < NK; k++) begin
            vectors++;
            if (obs_rd0[k] !== (32'h1234_5678 & cfg_dmask[k])) begin
                miscompares++;
                $display("FAIL bypass_commit cfg=%0d rd0=%h required %h",
                         k, obs_rd0[k], 32'h1234_5678 & cfg_dmask[k]);
            end
        end
        tick();
    endtask

    task automatic test_zero_reg();
        logic [31:0] req [NK];
        we = 1'b1; write_addr = 5'd0; write_data = 32'hFFFF_FFFF;
        read0_addr = 5'd0; read1_addr = 5'd0;
        tick();
        we = 1'b0;
        req[0] = 32'h0;
        req[1] = 32'hFFFF_FFFF;
        req[2] = 32'h0;
        #1;
        for (int k = 0; k < NK; k++) begin
            vectors++;
            if (obs_rd0[k] !== req[k] || obs_drop[k] !== 1'b0) begin
                miscompares++;
                $display("FAIL zero_reg cfg=%0d rd0=%h drop=%b required %h/0",
                         k, obs_rd0[k], obs_drop[k], req[k]);
            end
        end
        tick();
    endtask

    task automatic test_clear_drop();
        int waited;
        for (int a = 1; a < 32; a++) begin
            we = 1'b1; write_addr = 5'(a); write_data = $urandom;
            tick();
        end
        we = 1'b1; write_addr = 5'd2; write_data = 32'h5555_AAAA; clr = 1'b1;
        tick();
        clr = 1'b0; we = 1'b0;
        #1;
        for (int k = 0; k < NK; k++) begin
            vectors++;
            if (obs_ready[k] !== 1'b0) begin
                miscompares++;
                $display("FAIL clr_ready_fall cfg=%0d ready=%b required 0", k, obs_ready[k]);
            end
        end
        we = 1'b1; write_addr = 5'd9; write_data = 32'hAAAA_5555;
        tick();
        we = 1'b0;
        #1;
        for (int k = 0; k < NK; k++) begin
            vectors++;
            if (obs_drop[k] !== 1'b1) begin
                miscompares++;
                $display("FAIL wr_drop_pulse cfg=%0d drop=%b required 1", k, obs_drop[k]);
            end
        end
        tick();
        #1;
        for (int k = 0; k < NK; k++) begin
            vectors++;
            if (obs_drop[k] !== 1'b0) begin
                miscompares++;
                $display("FAIL wr_drop_end cfg=%0d drop=%b required 0", k, obs_drop[k]);
            end
        end
        waited = 0;
        while (mdl_left[0] != 0 && waited < 64) begin
            #1;
            for (int k = 0; k < NK; k++) begin
                vectors++;
                if (obs_ready[k] !== (mdl_left[k] == 0)) begin
                    miscompares++;
                    $display("FAIL sweep_ready cfg=%0d ready=%b required %b", k, obs_ready[k], (mdl_left[k] == 0));
                end
            end
            tick();
            waited++;
        end
        for (int a = 0; a < 32; a++) begin
            read0_addr = 5'(a); read1_addr = 5'(a);
            #1;
            for (int k = 0; k < NK; k++) begin
                vectors++;
                if (obs_ready[k] !== 1'b1 || obs_rd0[k] !== 32'h0 || obs_rd1[k] !== 32'h0) begin
                    miscompares++;
                    $display("FAIL post_clear cfg=%0d addr=%0d ready=%b rd0=%h rd1=%h required 1/0/0",
                             k, a, obs_ready[k], obs_rd0[k], obs_rd1[k]);
                end
            end
            tick();
        end
    endtask

    task automatic test_mid_reset();
        int first_ready [NK];
        clr = 1'b1;
        tick();
        clr = 1'b0;
        repeat (9) tick();
        rst_all = 1'b1;
        repeat (2) tick();
        rst_all = 1'b0;
        for (int k = 0; k < NK; k++) first_ready[k] = -1;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            #1;
            for (int k = 0; k < NK; k++)
                if (obs_ready[k] === 1'b1 && first_ready[k] < 0) first_ready[k] = cyc;
            tick();
        end
        for (int k = 0; k < NK; k++) begin
            vectors++;
            if (first_ready[k] != cfg_depth[k] + 1) begin
                miscompares++;
                $display("FAIL mid_reset_latency cfg=%0d first ready cycle %0d required %0d",
                         k, first_ready[k], cfg_depth[k] + 1);
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int cyc = 0; cyc < 600; cyc++) begin
            rst_all    = ($urandom_range(0, 299) == 0);
            clr        = ($urandom_range(0, 59) == 0);
            we         = ($urandom_range(0, 1) == 1);
            write_addr = 5'($urandom_range(0, 31));
            write_data = $urandom;
            read0_addr = ($urandom_range(0, 3) == 0) ? write_addr : 5'($urandom_range(0, 31));
            read1_addr = ($urandom_range(0, 3) == 0) ? write_addr : 5'($urandom_range(0, 31));
            #1;
            for (int k = 0; k < NK; k++) begin
                vectors++;
                if (obs_ready[k] !== (mdl_left[k] == 0) || obs_drop[k] !== mdl_drop[k] ||
                    obs_rd0[k] !== exp_read(k, read0_addr) ||
                    obs_rd1[k] !== exp_read(k, read1_addr)) begin
                    miscompares++;
                    $display("FAIL random cfg=%0d cyc=%0d ready=%b drop=%b rd0=%h rd1=%h required %b/%b/%h/%h",
                             k, cyc, obs_ready[k], obs_drop[k], obs_rd0[k], obs_rd1[k],
                             (mdl_left[k] == 0), mdl_drop[k],
                             exp_read(k, read0_addr), exp_read(k, read1_addr));
                end
            end
            tick();
        end
        rst_all = 1'b0; clr = 1'b0; we = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < NK; k++) begin
            mdl_left[k] = cfg_depth[k];
            mdl_drop[k] = 1'b0;
            for (int i = 0; i < 32; i++) mdl_mem[k][i] = 32'h0;
        end
        @(negedge clk);
        test_reset();
        test_write_read();
        test_bypass();
        test_zero_reg();
        test_clear_drop();
        test_mid_reset();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
